// File: rtl/lock_sequencer_if.sv
// Keypad-side and display-side signals of the combination-lock sequencer.
// The master drives key events and relock/reprogram requests; the slave reports state.
interface lock_sequencer_if;
  logic [3:0] digit_in;
  logic       digit_vld;
  logic       close_req;
  logic       prog_req;
  logic [2:0] state_out;
  logic [1:0] disp_sel;
  logic [3:0] echo_digit;
  logic [2:0] pos;
  logic [1:0] fail_cnt;
  logic       code_wr_done;

  // digit_vld is a one-cycle strobe with no ready: every cycle it is high one
  // digit is consumed, so holding it high enters one digit per cycle.
  modport master (
    output digit_in, digit_vld, close_req, prog_req,
    input  state_out, disp_sel, echo_digit, pos, fail_cnt, code_wr_done
  );

  modport slave (
    input  digit_in, digit_vld, close_req, prog_req,
    output state_out, disp_sel, echo_digit, pos, fail_cnt, code_wr_done
  );
endinterface

// File: rtl/lock_sequencer.sv
// Combination-lock control FSM: checks 6-digit BCD entry against a stored,
// reprogrammable code, counts failed attempts and enforces a timed lockout.
module lock_sequencer #(
  parameter logic [23:0] CODE_RESET  = 24'h305464,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  lock_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  localparam logic [2:0] LAST_POS  = 3'd5;
  localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  pos_q, pos_d;
  logic [1:0]  fail_q, fail_d;
  logic [3:0]  echo_q, echo_d;
  logic [1:0]  disp_q, disp_d;
  logic        wr_q, wr_d;
  logic [7:0]  timer_q, timer_d;
  logic [23:0] code_q, code_d;
  logic [23:0] shadow_q, shadow_d;
  logic        mis_q, mis_d;

  logic        digit_ok;
  logic [3:0]  code_digit;
  logic        digit_match;
  logic [2:0]  fail_inc;

  assign digit_ok    = (bus.digit_in <= 4'd9);
  assign digit_match = digit_ok && (bus.digit_in == code_digit);
  assign fail_inc    = {1'b0, fail_q} + 3'd1;

  // First entered digit is compared against the most significant nibble.
  always_comb begin
    case (pos_q)
      3'd0:    code_digit = code_q[23:20];
      3'd1:    code_digit = code_q[19:16];
      3'd2:    code_digit = code_q[15:12];
      3'd3:    code_digit = code_q[11:8];
      3'd4:    code_digit = code_q[7:4];
      3'd5:    code_digit = code_q[3:0];
      default: code_digit = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    fail_d   = fail_q;
    echo_d   = echo_q;
    timer_d  = timer_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    mis_d    = mis_q;
    wr_d     = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (bus.digit_vld) begin
          echo_d = bus.digit_in;
          if (pos_q != LAST_POS) begin
            pos_d = pos_q + 3'd1;
            mis_d = mis_q | ~digit_match;
          end else begin
            // Sixth digit: judge the whole attempt and start the next one clean.
            pos_d = 3'd0;
            mis_d = 1'b0;
            if (!mis_q && digit_match) begin
              state_d = ST_OPEN;
              fail_d  = 2'd0;
            end else if (fail_inc < MAX_FAIL_C) begin
              state_d = ST_CLOSED;
              fail_d  = fail_inc[1:0];
            end else begin
              state_d = ST_LOCKOUT;
              timer_d = LOCK_LOAD;
              fail_d  = fail_inc[1:0];
            end
          end
        end
      end

      ST_OPEN: begin
        if (bus.close_req) begin
          state_d = ST_ENTRY;
          pos_d   = 3'd0;
          mis_d   = 1'b0;
        end else if (bus.prog_req) begin
          state_d  = ST_PROG;
          pos_d    = 3'd0;
          shadow_d = 24'd0;
        end
      end

      ST_CLOSED: begin
        // The acknowledging key press is swallowed, not counted as a digit.
        if (bus.digit_vld) begin
          state_d = ST_ENTRY;
          pos_d   = 3'd0;
          mis_d   = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == 8'd0) begin
          state_d = ST_ENTRY;
          fail_d  = 2'd0;
          pos_d   = 3'd0;
          mis_d   = 1'b0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      ST_PROG: begin
        if (bus.digit_vld) begin
          if (!digit_ok) begin
            state_d  = ST_OPEN;
            pos_d    = 3'd0;
            shadow_d = 24'd0;
          end else begin
            echo_d   = bus.digit_in;
            shadow_d = {shadow_q[19:0], bus.digit_in};
            if (pos_q == LAST_POS) begin
              code_d  = {shadow_q[19:0], bus.digit_in};
              wr_d    = 1'b1;
              state_d = ST_ENTRY;
              pos_d   = 3'd0;
              fail_d  = 2'd0;
              mis_d   = 1'b0;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end
        end
      end

      default: begin
        state_d = ST_ENTRY;
        pos_d   = 3'd0;
        mis_d   = 1'b0;
      end
    endcase

    // Display select follows the next state so it stays aligned with state_out.
    case (state_d)
      ST_OPEN:    disp_d = 2'd1;
      ST_CLOSED:  disp_d = 2'd2;
      ST_LOCKOUT: disp_d = 2'd3;
      default:    disp_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ENTRY;
      pos_q    <= 3'd0;
      fail_q   <= 2'd0;
      echo_q   <= 4'd0;
      disp_q   <= 2'd0;
      wr_q     <= 1'b0;
      timer_q  <= 8'd0;
      code_q   <= CODE_RESET;
      shadow_q <= 24'd0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      fail_q   <= fail_d;
      echo_q   <= echo_d;
      disp_q   <= disp_d;
      wr_q     <= wr_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.state_out    = state_q;
  assign bus.disp_sel     = disp_q;
  assign bus.echo_digit   = echo_q;
  assign bus.pos          = pos_q;
  assign bus.fail_cnt     = fail_q;
  assign bus.code_wr_done = wr_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: a vector table for single-cycle behaviour
// plus hand sequences for reset, lockout timing and reprogramming.
module tb_lock_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  lock_sequencer_if bus ();

  lock_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [3:0] d;
    logic       cl;
    logic       pr;
    logic [2:0] st;
    logic [2:0] pos;
    logic [1:0] fail;
    logic [1:0] disp;
    logic       wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic vld, input logic [3:0] d,
                     input logic cl, input logic pr, input logic [2:0] st,
                     input logic [2:0] p, input logic [1:0] f,
                     input logic [1:0] ds, input logic w);
    vec_t v;
    v.name = nm; v.vld = vld; v.d = d; v.cl = cl; v.pr = pr;
    v.st = st; v.pos = p; v.fail = f; v.disp = ds; v.wr = w;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input string field, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic [2:0] p,
                     input logic [1:0] f, input logic [1:0] ds, input logic w);
    cmp(nm, "state_out", int'(bus.state_out), int'(st));
    cmp(nm, "pos", int'(bus.pos), int'(p));
    cmp(nm, "fail_cnt", int'(bus.fail_cnt), int'(f));
    cmp(nm, "disp_sel", int'(bus.disp_sel), int'(ds));
    cmp(nm, "code_wr_done", int'(bus.code_wr_done), int'(w));
  endtask

  // Drive inputs mid-cycle, then let one rising edge take effect.
  task automatic step(input logic vld, input logic [3:0] d, input logic cl, input logic pr);
    @(negedge clk);
    bus.digit_vld = vld;
    bus.digit_in  = d;
    bus.close_req = cl;
    bus.prog_req  = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic enter_code(input logic [23:0] code);
    for (int i = 0; i < 6; i++) step(1'b1, code[23 - 4*i -: 4], 1'b0, 1'b0);
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    bus.digit_vld = 1'b0;
    bus.close_req = 1'b0;
    bus.prog_req  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({nm, "_async"}, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);
    cmp(nm, "echo_digit", int'(bus.echo_digit), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_post"}, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    bus.digit_in  = 4'd0;
    bus.digit_vld = 1'b0;
    bus.close_req = 1'b0;
    bus.prog_req  = 1'b0;

    // Vector table: {name, vld, digit, close, prog, state, pos, fail, disp, wr}
    add("idle",      0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    add("ok_d0",     1, 4'h3, 0, 0, 0, 1, 0, 0, 0);
    add("req_entry", 0, 4'h0, 1, 1, 0, 1, 0, 0, 0);
    add("ok_d1",     1, 4'h0, 0, 0, 0, 2, 0, 0, 0);
    add("ok_d2",     1, 4'h5, 0, 0, 0, 3, 0, 0, 0);
    add("ok_d3",     1, 4'h4, 0, 0, 0, 4, 0, 0, 0);
    add("ok_d4",     1, 4'h6, 0, 0, 0, 5, 0, 0, 0);
    add("ok_d5",     1, 4'h4, 0, 0, 1, 0, 0, 1, 0);
    add("open_vld",  1, 4'h9, 0, 0, 1, 0, 0, 1, 0);
    add("close",     0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
    add("bad_d0",    1, 4'h3, 0, 0, 0, 1, 0, 0, 0);
    add("bad_d1",    1, 4'h0, 0, 0, 0, 2, 0, 0, 0);
    add("bad_d2",    1, 4'h5, 0, 0, 0, 3, 0, 0, 0);
    add("bad_d3",    1, 4'h4, 0, 0, 0, 4, 0, 0, 0);
    add("bad_d4",    1, 4'h6, 0, 0, 0, 5, 0, 0, 0);
    add("bad_d5",    1, 4'h5, 0, 0, 2, 0, 1, 2, 0);
    add("closed_req",0, 4'h0, 1, 1, 2, 0, 1, 2, 0);
    add("clear",     1, 4'h7, 0, 0, 0, 0, 1, 0, 0);
    add("re_d0",     1, 4'h3, 0, 0, 0, 1, 1, 0, 0);
    add("re_d1",     1, 4'h0, 0, 0, 0, 2, 1, 0, 0);
    add("re_d2",     1, 4'h5, 0, 0, 0, 3, 1, 0, 0);
    add("re_d3",     1, 4'h4, 0, 0, 0, 4, 1, 0, 0);
    add("re_d4",     1, 4'h6, 0, 0, 0, 5, 1, 0, 0);
    add("re_d5",     1, 4'h4, 0, 0, 1, 0, 0, 1, 0);
    add("both_req",  0, 4'h0, 1, 1, 0, 0, 0, 0, 0);
    add("inv_d0",    1, 4'h3, 0, 0, 0, 1, 0, 0, 0);
    add("inv_d1",    1, 4'h0, 0, 0, 0, 2, 0, 0, 0);
    add("inv_d2",    1, 4'hA, 0, 0, 0, 3, 0, 0, 0);
    add("inv_d3",    1, 4'h4, 0, 0, 0, 4, 0, 0, 0);
    add("inv_d4",    1, 4'h6, 0, 0, 0, 5, 0, 0, 0);
    add("inv_d5",    1, 4'h4, 0, 0, 2, 0, 1, 2, 0);
    add("inv_clear", 1, 4'h1, 0, 0, 0, 0, 1, 0, 0);
    add("fin_d0",    1, 4'h3, 0, 0, 0, 1, 1, 0, 0);
    add("fin_d1",    1, 4'h0, 0, 0, 0, 2, 1, 0, 0);
    add("fin_d2",    1, 4'h5, 0, 0, 0, 3, 1, 0, 0);
    add("fin_d3",    1, 4'h4, 0, 0, 0, 4, 1, 0, 0);
    add("fin_d4",    1, 4'h6, 0, 0, 0, 5, 1, 0, 0);
    add("fin_d5",    1, 4'h4, 0, 0, 1, 0, 0, 1, 0);
    add("fin_close", 0, 4'h0, 1, 0, 0, 0, 0, 0, 0);

    // Power-on reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por", 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].d, vecs[i].cl, vecs[i].pr);
      chk(vecs[i].name, vecs[i].st, vecs[i].pos, vecs[i].fail, vecs[i].disp, vecs[i].wr);
    end

    // Echo and mid-stream reset
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    cmp("echo", "echo_digit", int'(bus.echo_digit), 5);
    cmp("echo", "pos", int'(bus.pos), 3);
    pulse_reset("rst_mid");

    // Three failed attempts lead to lockout lasting exactly 16 cycles
    enter_code(24'h305465);
    chk("lk_try1", 3'd2, 3'd0, 2'd1, 2'd2, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    chk("lk_clr1", 3'd0, 3'd0, 2'd1, 2'd0, 1'b0);
    enter_code(24'h999999);
    chk("lk_try2", 3'd2, 3'd0, 2'd2, 2'd2, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    chk("lk_clr2", 3'd0, 3'd0, 2'd2, 2'd0, 1'b0);
    enter_code(24'h305460);
    chk("lk_enter", 3'd3, 3'd0, 2'd3, 2'd3, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 4'(i % 10), 1'(i % 2), 1'((i + 1) % 2));
      chk($sformatf("lk_hold%0d", i), 3'd3, 3'd0, 2'd3, 2'd3, 1'b0);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("lk_exit", 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);

    // Reprogram to 123456
    enter_code(24'h305464);
    chk("pg_open", 3'd1, 3'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("pg_enter", 3'd4, 3'd0, 2'd0, 2'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      chk($sformatf("pg_d%0d", i), 3'd4, 3'(i), 2'd0, 2'd0, 1'b0);
    end
    step(1'b1, 4'h6, 1'b0, 1'b0);
    chk("pg_commit", 3'd0, 3'd0, 2'd0, 2'd0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("pg_pulse_end", 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);
    enter_code(24'h305464);
    chk("pg_old_code", 3'd2, 3'd0, 2'd1, 2'd2, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    enter_code(24'h123456);
    chk("pg_new_code", 3'd1, 3'd0, 2'd0, 2'd1, 1'b0);

    // Invalid digit aborts programming, code unchanged
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("ab_partial", 3'd4, 3'd2, 2'd0, 2'd0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    chk("ab_abort", 3'd1, 3'd0, 2'd0, 2'd1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    enter_code(24'h123456);
    chk("ab_code_kept", 3'd1, 3'd0, 2'd0, 2'd1, 1'b0);

    // Reset during programming restores the reset combination
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    chk("rp_partial", 3'd4, 3'd2, 2'd0, 2'd0, 1'b0);
    pulse_reset("rst_prog");
    enter_code(24'h305464);
    chk("rp_reset_code", 3'd1, 3'd0, 2'd0, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
